// File: rtl/ioctl_region_loader_pkg.sv
// Shared types, default ioctl indices and the region-base unpacking helper
// for the ioctl region loader.
package ioctl_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } state_e;

    localparam logic [7:0] IDX_ROM = 8'd0;
    localparam logic [7:0] IDX_DIP = 8'd254;

    // Widest supported region table; callers zero-extend REGION_BASE into this.
    localparam int MAX_REGIONS = 8;
    localparam int MAX_AW      = 32;

    function automatic logic [MAX_AW-1:0] base_of(
        input logic [MAX_REGIONS*MAX_AW-1:0] bases,
        input int                            aw,
        input int                            i
    );
        logic [MAX_REGIONS*MAX_AW-1:0] shifted;
        logic [MAX_AW-1:0]             mask;
        shifted = bases >> (i * aw);
        mask    = (MAX_AW'(1) << aw) - MAX_AW'(1);
        return shifted[MAX_AW-1:0] & mask;
    endfunction

endpackage

// File: rtl/ioctl_region_loader_if.sv
// hps_io ioctl stream as seen by the region loader; hps_io is the master.
interface ioctl_region_loader_if #(
    parameter int ADDR_W = 27
);
    logic              ioctl_download;
    logic [7:0]        ioctl_index;
    logic              ioctl_wr;
    logic [ADDR_W-1:0] ioctl_addr;
    logic [15:0]       ioctl_dout;
    logic              ioctl_wait;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        input  ioctl_wait
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        output ioctl_wait
    );
endinterface

// File: rtl/ioctl_region_loader_decode.sv
// Combinational address decode: picks the highest region whose base is <= addr
// and reports whether the region-local offset fits inside 2**ROM_AW bytes.
module ioctl_region_decode
    import ioctl_loader_pkg::*;
#(
    parameter int NUM_REGIONS = 4,
    parameter int ADDR_W      = 27,
    parameter int ROM_AW      = 16,
    parameter int RW          = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = '0
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic              hit_o,
    output logic [RW-1:0]     region_o,
    output logic [ROM_AW-1:0] off_o
);
    localparam logic [MAX_REGIONS*MAX_AW-1:0] BASES = (MAX_REGIONS*MAX_AW)'(REGION_BASE);

    logic [NUM_REGIONS-1:0] ge;
    logic [ADDR_W-1:0]      base_arr [NUM_REGIONS];
    logic [ADDR_W-1:0]      base_sel;
    logic [ADDR_W-1:0]      diff;
    logic                   any_ge;
    logic                   in_rng;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGIONS; gi++) begin : g_cmp
            assign base_arr[gi] = ADDR_W'(base_of(BASES, ADDR_W, gi));
            assign ge[gi]       = (addr_i >= base_arr[gi]);
        end
    endgenerate

    // Bases ascend, so the last matching compare is the owning region.
    always_comb begin
        region_o = '0;
        base_sel = '0;
        any_ge   = 1'b0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (ge[i]) begin
                region_o = RW'(i);
                base_sel = base_arr[i];
                any_ge   = 1'b1;
            end
        end
    end

    assign diff = addr_i - base_sel;

    generate
        if (ADDR_W > ROM_AW) begin : g_rng
            assign in_rng = ~|diff[ADDR_W-1:ROM_AW];
        end else begin : g_norng
            assign in_rng = 1'b1;
        end
    endgenerate

    assign off_o = diff[ROM_AW-1:0];
    assign hit_o = any_ge & in_rng;
endmodule

// File: rtl/ioctl_region_loader.sv
// Routes 16-bit ioctl words into byte-wide ROM regions (two strobes per word,
// throttled via ioctl_wait) and captures DIP switch bytes.
module ioctl_region_loader
    import ioctl_loader_pkg::*;
#(
    parameter int NUM_REGIONS = 4,
    parameter int ADDR_W      = 27,
    parameter int ROM_AW      = 16,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = '0,
    parameter int DIP_BYTES   = 8,
    parameter logic [7:0] ROM_INDEX = IDX_ROM,
    parameter logic [7:0] DIP_INDEX = IDX_DIP
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    ioctl_region_loader_if.slave   ioctl,
    output logic [NUM_REGIONS-1:0] rom_we_o,
    output logic [ROM_AW-1:0]      rom_addr_o,
    output logic [7:0]             rom_data_o,
    output logic [DIP_BYTES*8-1:0] dip_out_o,
    output logic                   dl_busy_o,
    output logic                   dl_done_o,
    output logic                   err_range_o,
    output logic                   err_overrun_o
);
    localparam int RW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    state_e                 state_q, state_d;
    logic [NUM_REGIONS-1:0] rom_we_q, rom_we_d;
    logic [ROM_AW-1:0]      rom_addr_q, rom_addr_d;
    logic [7:0]             rom_data_q, rom_data_d;
    logic                   wait_q, wait_d;
    logic [NUM_REGIONS-1:0] sel_q, sel_d;
    logic [ROM_AW-1:0]      off_q, off_d;
    logic [7:0]             hi_q, hi_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_range_q, err_range_d;
    logic                   err_overrun_q, err_overrun_d;
    logic                   dl_prev_q;
    logic [7:0]             dip_q [DIP_BYTES];

    logic                   dec_hit;
    logic [RW-1:0]          dec_r;
    logic [ROM_AW-1:0]      dec_off;
    logic                   rom_wr, accept, overrun, dl_rise, dip_hit;

    ioctl_region_decode #(
        .NUM_REGIONS (NUM_REGIONS),
        .ADDR_W      (ADDR_W),
        .ROM_AW      (ROM_AW),
        .RW          (RW),
        .REGION_BASE (REGION_BASE)
    ) u_decode (
        .addr_i   (ioctl.ioctl_addr),
        .hit_o    (dec_hit),
        .region_o (dec_r),
        .off_o    (dec_off)
    );

    assign rom_wr  = ioctl.ioctl_wr & (ioctl.ioctl_index == ROM_INDEX);
    assign accept  = rom_wr & ioctl.ioctl_download & (state_q == IDLE);
    assign overrun = rom_wr & (state_q != IDLE);
    assign dl_rise = ioctl.ioctl_download & ~dl_prev_q & (ioctl.ioctl_index == ROM_INDEX);
    assign dip_hit = ioctl.ioctl_wr & (ioctl.ioctl_index == DIP_INDEX)
                   & (ioctl.ioctl_addr < ADDR_W'(DIP_BYTES));

    // Outputs are computed one state ahead so each state's strobe is registered.
    always_comb begin
        state_d    = state_q;
        rom_we_d   = '0;
        rom_addr_d = '0;
        rom_data_d = '0;
        wait_d     = 1'b0;
        sel_d      = sel_q;
        off_d      = off_q;
        hi_d       = hi_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = WR_LO;
                    wait_d     = 1'b1;
                    sel_d      = dec_hit ? (NUM_REGIONS'(1) << dec_r) : '0;
                    off_d      = dec_off;
                    hi_d       = ioctl.ioctl_dout[15:8];
                    rom_we_d   = sel_d;
                    rom_addr_d = dec_off;
                    rom_data_d = ioctl.ioctl_dout[7:0];
                end
            end
            WR_LO: begin
                state_d    = WR_HI;
                wait_d     = 1'b1;
                rom_we_d   = sel_q;
                rom_addr_d = off_q | ROM_AW'(1);
                rom_data_d = hi_q;
            end
            WR_HI:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // dl_done looks at the upcoming state so an in-flight word finishes first.
    always_comb begin
        done_d        = busy_q & ~ioctl.ioctl_download & (state_d == IDLE);
        busy_d        = dl_rise ? 1'b1 : (done_d ? 1'b0 : busy_q);
        err_range_d   = dl_rise ? 1'b0 : err_range_q;
        err_overrun_d = dl_rise ? 1'b0 : err_overrun_q;
        if (accept && !dec_hit) err_range_d = 1'b1;
        if (overrun)            err_overrun_d = 1'b1;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            rom_we_q      <= '0;
            rom_addr_q    <= '0;
            rom_data_q    <= '0;
            wait_q        <= 1'b0;
            sel_q         <= '0;
            off_q         <= '0;
            hi_q          <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_range_q   <= 1'b0;
            err_overrun_q <= 1'b0;
            dl_prev_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rom_we_q      <= rom_we_d;
            rom_addr_q    <= rom_addr_d;
            rom_data_q    <= rom_data_d;
            wait_q        <= wait_d;
            sel_q         <= sel_d;
            off_q         <= off_d;
            hi_q          <= hi_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_range_q   <= err_range_d;
            err_overrun_q <= err_overrun_d;
            dl_prev_q     <= ioctl.ioctl_download;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DIP_BYTES; k++) dip_q[k] <= '0;
        end else if (dip_hit) begin
            for (int k = 0; k < DIP_BYTES; k++) begin
                if (ioctl.ioctl_addr == ADDR_W'(k)) dip_q[k] <= ioctl.ioctl_dout[7:0];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DIP_BYTES; gi++) begin : g_dip
            assign dip_out_o[gi*8 +: 8] = dip_q[gi];
        end
    endgenerate

    assign ioctl.ioctl_wait = wait_q;
    assign rom_we_o         = rom_we_q;
    assign rom_addr_o       = rom_addr_q;
    assign rom_data_o       = rom_data_q;
    assign dl_busy_o        = busy_q;
    assign dl_done_o        = done_q;
    assign err_range_o      = err_range_q;
    assign err_overrun_o    = err_overrun_q;
endmodule

// File: tb/tb_ioctl_region_loader.sv
// Directed bench for ioctl_region_loader with a scoreboard of expected ROM byte writes.
module tb_ioctl_region_loader;
    localparam int NR = 4;
    localparam int AW = 27;
    localparam int RA = 14;
    localparam int DB = 8;
    localparam logic [NR*AW-1:0] BASES = {27'hC000, 27'h8000, 27'h4000, 27'h0};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ioctl_region_loader_if #(.ADDR_W(AW)) bus ();

    logic [NR-1:0]   rom_we;
    logic [RA-1:0]   rom_addr;
    logic [7:0]      rom_data;
    logic [DB*8-1:0] dip_out;
    logic            dl_busy, dl_done, err_range, err_overrun;

    ioctl_region_loader #(
        .NUM_REGIONS (NR),
        .ADDR_W      (AW),
        .ROM_AW      (RA),
        .REGION_BASE (BASES),
        .DIP_BYTES   (DB),
        .ROM_INDEX   (8'd0),
        .DIP_INDEX   (8'd254)
    ) dut (
        .clk_sys       (clk),
        .reset         (rst),
        .ioctl         (bus),
        .rom_we_o      (rom_we),
        .rom_addr_o    (rom_addr),
        .rom_data_o    (rom_data),
        .dip_out_o     (dip_out),
        .dl_busy_o     (dl_busy),
        .dl_done_o     (dl_done),
        .err_range_o   (err_range),
        .err_overrun_o (err_overrun)
    );

    typedef struct packed {
        logic [NR-1:0] we;
        logic [RA-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    wr_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  we_total = 0;
    int  wait_total = 0;
    int  done_total = 0;
    int  we_before;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mon();
        wr_t e;
        if (rom_we !== '0) begin
            we_total++;
            $display("t=%0t rom write we=%b addr=%h data=%h", $time, rom_we, rom_addr, rom_data);
            if (sb.size() == 0) begin
                chk("unexpected_rom_we", 64'(rom_we), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("rom_we", 64'(rom_we), 64'(e.we));
                chk("rom_addr", 64'(rom_addr), 64'(e.addr));
                chk("rom_data", 64'(rom_data), 64'(e.data));
            end
        end
        if (bus.ioctl_wait === 1'b1) wait_total++;
        if (dl_done === 1'b1) done_total++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        mon();
    endtask

    task automatic word(input logic [AW-1:0] a, input logic [15:0] d);
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = a;
        bus.ioctl_dout = d;
        step();
        bus.ioctl_wr   = 1'b0;
    endtask

    initial begin
        rst                = 1'b1;
        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = 8'd0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rom_we", 64'(rom_we), 64'd0);
        chk("rst_wait", 64'(bus.ioctl_wait), 64'd0);
        chk("rst_dip", 64'(dip_out), 64'd0);
        chk("rst_flags", 64'({dl_busy, dl_done, err_range, err_overrun}), 64'd0);
        rst = 1'b0;

        // ROM download start
        bus.ioctl_download = 1'b1;
        bus.ioctl_index    = 8'd0;
        step();
        chk("busy_set", 64'(dl_busy), 64'd1);

        // Word 0xBBAA at 0x4002 -> region 1
        wait_total = 0;
        sb.push_back('{4'b0010, 14'h0002, 8'hAA});
        sb.push_back('{4'b0010, 14'h0003, 8'hBB});
        word(27'h4002, 16'hBBAA);
        chk("t1_wait_n1", 64'(bus.ioctl_wait), 64'd1);
        step();
        chk("t1_wait_n2", 64'(bus.ioctl_wait), 64'd1);
        step();
        chk("t1_wait_n3", 64'(bus.ioctl_wait), 64'd0);
        chk("t1_we_n3", 64'(rom_we), 64'd0);
        chk("t1_wait_cycles", 64'(wait_total), 64'd2);
        chk("t1_sb_empty", 64'(sb.size()), 64'd0);

        // Last in-range word of region 3
        sb.push_back('{4'b1000, 14'h3FFE, 8'hCC});
        sb.push_back('{4'b1000, 14'h3FFF, 8'hDD});
        word(27'hFFFE, 16'hDDCC);
        step();
        step();
        chk("edge_sb_empty", 64'(sb.size()), 64'd0);
        chk("edge_no_range", 64'(err_range), 64'd0);

        // Out of range: 0x10000 is past region 3
        wait_total = 0;
        we_before  = we_total;
        word(27'h10000, 16'h1111);
        step();
        step();
        chk("t3_err_range", 64'(err_range), 64'd1);
        chk("t3_no_we", 64'(we_total - we_before), 64'd0);
        chk("t3_wait_cycles", 64'(wait_total), 64'd2);

        // Overrun: second strobe at N+1 dropped
        we_before = we_total;
        sb.push_back('{4'b0100, 14'h0000, 8'h11});
        sb.push_back('{4'b0100, 14'h0001, 8'h22});
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = 27'h8000;
        bus.ioctl_dout = 16'h2211;
        step();
        bus.ioctl_addr = 27'hC000;
        bus.ioctl_dout = 16'h9999;
        step();
        bus.ioctl_wr = 1'b0;
        step();
        step();
        chk("t4_err_overrun", 64'(err_overrun), 64'd1);
        chk("t4_we_pulses", 64'(we_total - we_before), 64'd2);
        chk("t4_sb_empty", 64'(sb.size()), 64'd0);

        // Download ends while in WR_LO
        done_total = 0;
        sb.push_back('{4'b0001, 14'h0000, 8'h33});
        sb.push_back('{4'b0001, 14'h0001, 8'h44});
        word(27'h0, 16'h4433);
        bus.ioctl_download = 1'b0;
        chk("t5_done_n1", 64'(dl_done), 64'd0);
        step();
        chk("t5_done_n2", 64'(dl_done), 64'd0);
        chk("t5_busy_n2", 64'(dl_busy), 64'd1);
        step();
        chk("t5_done_n3", 64'(dl_done), 64'd1);
        chk("t5_busy_n3", 64'(dl_busy), 64'd0);
        step();
        chk("t5_done_n4", 64'(dl_done), 64'd0);
        chk("t5_done_count", 64'(done_total), 64'd1);

        // DIP writes
        wait_total      = 0;
        bus.ioctl_index = 8'd254;
        word(27'd3, 16'h125A);
        chk("t2_dip_byte3", 64'(dip_out), 64'h0000_0000_5A00_0000);
        word(27'd9, 16'h00FF);
        step();
        chk("t2_dip_ignored", 64'(dip_out), 64'h0000_0000_5A00_0000);
        chk("t2_no_wait", 64'(wait_total), 64'd0);

        // New download clears flags; reset mid-word
        bus.ioctl_index    = 8'd0;
        bus.ioctl_download = 1'b1;
        step();
        chk("t6_err_clear", 64'({err_range, err_overrun}), 64'd0);
        chk("t6_busy", 64'(dl_busy), 64'd1);
        sb.push_back('{4'b0001, 14'h0010, 8'h66});
        word(27'h10, 16'h7766);
        bus.ioctl_download = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_we", 64'(rom_we), 64'd0);
        chk("t6_rst_wait", 64'(bus.ioctl_wait), 64'd0);
        chk("t6_rst_dip", 64'(dip_out), 64'd0);
        chk("t6_rst_bus", 64'({rom_addr, rom_data}), 64'd0);
        chk("t6_rst_flags", 64'({dl_busy, dl_done, err_range, err_overrun}), 64'd0);
        step();
        rst = 1'b0;
        step();
        step();
        chk("t6_sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
